// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide unit: mult/multu commit 5 cycles after start, div/divu 10; mthi/mtlo in 1.
// No handshake: busy_o/stall_o hold the D stage while an op is in flight; ops presented while busy are dropped.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        IntReq,
  input  logic [3:0]  E_mdOp_i,
  input  logic [31:0] E_rsValue_i,
  input  logic [31:0] E_rtValue_i,
  input  logic        D_mdUse_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic [31:0] HI_o,
  output logic [31:0] LO_o
);

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  logic [3:0]  cnt;
  md_op_e      op_q;
  logic [31:0] rs_q;
  logic [31:0] rt_q;

  logic        is_md;
  logic        start;
  logic        is_mult_op;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign is_md      = (E_mdOp_i >= 4'd1) && (E_mdOp_i <= 4'd4);
  assign is_mult_op = (E_mdOp_i == MD_MULT) || (E_mdOp_i == MD_MULTU);
  assign busy_o     = (cnt != 4'd0);
  assign start      = is_md && !busy_o && !IntReq;
  assign stall_o    = D_mdUse_i && (busy_o || is_md);

  // Arithmetic works only on the latched operands, so E-stage forwarding changes cannot leak in.
  assign prod_s = $signed({{32{rs_q[31]}}, rs_q}) * $signed({{32{rt_q[31]}}, rt_q});
  assign prod_u = {32'd0, rs_q} * {32'd0, rt_q};
  assign quo_s  = $signed(rs_q) / $signed(rt_q);
  assign rem_s  = $signed(rs_q) % $signed(rt_q);
  assign quo_u  = rs_q / rt_q;
  assign rem_u  = rs_q % rt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 4'd0;
      op_q <= MD_NONE;
      rs_q <= 32'd0;
      rt_q <= 32'd0;
      HI_o <= 32'd0;
      LO_o <= 32'd0;
    end else if (busy_o) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        unique case (op_q)
          MD_MULT:  {HI_o, LO_o} <= prod_s;
          MD_MULTU: {HI_o, LO_o} <= prod_u;
          MD_DIV: if (rt_q != 32'd0) begin
            HI_o <= rem_s;
            LO_o <= quo_s;
          end
          MD_DIVU: if (rt_q != 32'd0) begin
            HI_o <= rem_u;
            LO_o <= quo_u;
          end
          default: ;
        endcase
      end
    end else if (start) begin
      cnt  <= is_mult_op ? 4'd5 : 4'd10;
      op_q <= md_op_e'(E_mdOp_i);
      rs_q <= E_rsValue_i;
      rt_q <= E_rtValue_i;
    end else if (!IntReq) begin
      if (E_mdOp_i == MD_MTHI) HI_o <= E_rsValue_i;
      if (E_mdOp_i == MD_MTLO) LO_o <= E_rsValue_i;
    end
  end

endmodule
